// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam logic ARB_M_CORE = 1'b0;
    localparam logic ARB_M_DMA  = 1'b1;

    // Counter width able to hold 0..limit; a disabled watchdog (limit 0) still gets one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One valid/ready memory port: request fields from the master, completion back from the slave.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     wdata;
    logic                  ready;
    logic                  err;
    logic [DATA_W-1:0]     rdata;

    // Requester side of a port.
    modport master (output valid, addr, wstrb, wdata, input ready, err, rdata);
    // Responder side of a port.
    modport slave  (input valid, addr, wstrb, wdata, output ready, err, rdata);
    // Requester towards the memory, which has no error return.
    modport mem_master (output valid, addr, wstrb, wdata, input ready, rdata);
endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Granted-cycle counter: expires in the granted cycle whose ordinal equals limit.
module bus_watchdog #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   ordinal;

    // Clear has priority; otherwise count enabled cycles, holding at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of earlier granted cycles, so the current one is cnt_q+1.
    assign ordinal = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign expired = enable && (limit != '0) && (ordinal >= {1'b0, limit});

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, one-slave valid/ready arbiter with round-robin or fixed priority,
// per-transaction bus lock and a watchdog that ends hung transactions with err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_arbiter_if.slave        m0,
    mem_arbiter_if.slave        m1,
    mem_arbiter_if.mem_master   s
);
    localparam int CNT_W  = cnt_width(TIMEOUT);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;

    logic              granted;
    logic              g_sel;
    logic              g_valid;
    logic [ADDR_W-1:0] g_addr;
    logic [STRB_W-1:0] g_wstrb;
    logic [DATA_W-1:0] g_wdata;
    logic              wd_expired;

    logic              s_valid;
    logic [ADDR_W-1:0] s_addr;
    logic [STRB_W-1:0] s_wstrb;
    logic [DATA_W-1:0] s_wdata;
    logic              fin;
    logic              tmo;

    assign granted = (state_q == GRANT0) || (state_q == GRANT1);
    assign g_sel   = (state_q == GRANT1);

    // Request fields of whichever master currently owns the bus.
    always_comb begin
        g_valid = g_sel ? m1.valid : m0.valid;
        g_addr  = g_sel ? m1.addr  : m0.addr;
        g_wstrb = g_sel ? m1.wstrb : m0.wstrb;
        g_wdata = g_sel ? m1.wdata : m0.wdata;
    end

    bus_watchdog #(.CNT_W(CNT_W)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!granted),
        .enable  (granted),
        .limit   (CNT_W'(TIMEOUT)),
        .expired (wd_expired)
    );

    // Arbitration, slave-side drive and completion decode.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        s_valid      = 1'b0;
        s_addr       = '0;
        s_wstrb      = '0;
        s_wdata      = '0;
        fin          = 1'b0;
        tmo          = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On a tie, round-robin favours the master not granted last.
                if (m0.valid && (!m1.valid || !ROUND_ROBIN || (last_grant_q == ARB_M_DMA))) begin
                    state_d = GRANT0;
                end else if (m1.valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                s_valid = g_valid;
                s_addr  = g_addr;
                s_wstrb = g_wstrb;
                s_wdata = g_wdata;
                if (!g_valid) begin
                    // Owner withdrew its request: release the bus silently.
                    state_d = IDLE;
                end else if (s.ready || wd_expired) begin
                    // A real completion beats a coincident watchdog expiry.
                    fin          = 1'b1;
                    tmo          = !s.ready;
                    s_valid      = !tmo;
                    state_d      = IDLE;
                    last_grant_d = g_sel;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and fairness history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ARB_M_DMA;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign s.valid  = s_valid;
    assign s.addr   = s_addr;
    assign s.wstrb  = s_wstrb;
    assign s.wdata  = s_wdata;

    assign m0.ready = fin && (g_sel == ARB_M_CORE);
    assign m1.ready = fin && (g_sel == ARB_M_DMA);
    assign m0.err   = tmo && (g_sel == ARB_M_CORE);
    assign m1.err   = tmo && (g_sel == ARB_M_DMA);
    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: dut 0 is round-robin with TIMEOUT=4, dut 1 fixed priority, watchdog off.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n [2];
    logic          mv    [2][2];
    logic [AW-1:0] ma    [2][2];
    logic [SW-1:0] mws   [2][2];
    logic [DW-1:0] mwd   [2][2];
    logic          mrdy  [2][2];
    logic          merr  [2][2];
    logic [DW-1:0] mrd   [2][2];
    logic          sv    [2];
    logic [AW-1:0] sa    [2];
    logic [SW-1:0] sws   [2];
    logic [DW-1:0] swd   [2];
    logic          srdy  [2];
    logic [DW-1:0] srd   [2];

    int n_vec = 0;
    int n_err = 0;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mi0 ();
        mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mi1 ();
        mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) si ();
        assign mi0.valid = mv[d][0];  assign mi1.valid = mv[d][1];
        assign mi0.addr  = ma[d][0];  assign mi1.addr  = ma[d][1];
        assign mi0.wstrb = mws[d][0]; assign mi1.wstrb = mws[d][1];
        assign mi0.wdata = mwd[d][0]; assign mi1.wdata = mwd[d][1];
        assign mrdy[d][0] = mi0.ready; assign mrdy[d][1] = mi1.ready;
        assign merr[d][0] = mi0.err;   assign merr[d][1] = mi1.err;
        assign mrd[d][0]  = mi0.rdata; assign mrd[d][1]  = mi1.rdata;
        assign si.ready = srdy[d];
        assign si.rdata = srd[d];
        assign si.err   = 1'b0;
        assign sv[d]  = si.valid;
        assign sa[d]  = si.addr;
        assign sws[d] = si.wstrb;
        assign swd[d] = si.wdata;
        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(d == 0), .TIMEOUT(d == 0 ? 4 : 0)) u_dut (
            .clk(clk), .rst_n(rst_n[d]), .m0(mi0), .m1(mi1), .s(si));
    end

    typedef struct packed {
        logic          sv;
        logic [AW-1:0] sa;
        logic [SW-1:0] sws;
        logic [DW-1:0] swd;
        logic [1:0]    rdy;
        logic [1:0]    err;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
    } outs_t;

    typedef struct {
        logic [1:0]    mv;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [SW-1:0] ws1;
        logic [DW-1:0] wd1;
        logic          srdy;
        logic [DW-1:0] rd;
        outs_t         exp;
    } vec_t;

    vec_t tbl [$];

    function automatic outs_t o(input logic v, input logic [AW-1:0] a, input logic [SW-1:0] ws,
                                input logic [DW-1:0] wd, input logic [1:0] r, input logic [1:0] e,
                                input logic [DW-1:0] rd);
        outs_t x;
        x.sv = v; x.sa = a; x.sws = ws; x.swd = wd; x.rdy = r; x.err = e;
        x.rd0 = r[0] ? rd : '0;
        x.rd1 = r[1] ? rd : '0;
        return x;
    endfunction

    function automatic outs_t sample(input int d);
        outs_t x;
        x.sv = sv[d]; x.sa = sa[d]; x.sws = sws[d]; x.swd = swd[d];
        x.rdy = {mrdy[d][1], mrdy[d][0]};
        x.err = {merr[d][1], merr[d][0]};
        x.rd0 = mrdy[d][0] ? mrd[d][0] : '0;
        x.rd1 = mrdy[d][1] ? mrd[d][1] : '0;
        return x;
    endfunction

    task automatic check(input int d, input string name, input outs_t e);
        outs_t a;
        a = sample(d);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got sv=%b sa=%h ws=%b wd=%h rdy=%b err=%b rd0=%h rd1=%h | want sv=%b sa=%h ws=%b wd=%h rdy=%b err=%b rd0=%h rd1=%h",
                     name, d, $time, a.sv, a.sa, a.sws, a.swd, a.rdy, a.err, a.rd0, a.rd1,
                     e.sv, e.sa, e.sws, e.swd, e.rdy, e.err, e.rd0, e.rd1);
        end
    endtask

    task automatic row(input logic [1:0] m, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [SW-1:0] ws1, input logic [DW-1:0] wd1, input logic r,
                       input logic [DW-1:0] rd, input outs_t e);
        vec_t t;
        t.mv = m; t.a0 = a0; t.a1 = a1; t.ws1 = ws1; t.wd1 = wd1; t.srdy = r; t.rd = rd; t.exp = e;
        tbl.push_back(t);
    endtask

    task automatic drive(input int d, input logic [1:0] m, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [SW-1:0] ws1,
                         input logic [DW-1:0] wd1, input logic r, input logic [DW-1:0] rd);
        mv[d][0] = m[0]; mv[d][1] = m[1];
        ma[d][0] = a0;   ma[d][1] = a1;
        mws[d][0] = '0;  mws[d][1] = ws1;
        mwd[d][0] = '0;  mwd[d][1] = wd1;
        srdy[d] = r;     srd[d] = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference used for the randomized phase.
    int owner [2];
    int last  [2];
    int age   [2];
    int lim   [2];
    bit rrb   [2];

    task automatic model_out(input int d, output outs_t e, output bit fin, output bit abort);
        int  n;
        bit  tmo;
        e = '0; fin = 0; abort = 0;
        if (owner[d] >= 0) begin
            n = owner[d];
            e.sa = ma[d][n]; e.sws = mws[d][n]; e.swd = mwd[d][n];
            if (!mv[d][n]) begin
                abort = 1;
            end else begin
                tmo = (lim[d] != 0) && (age[d] + 1 >= lim[d]) && !srdy[d];
                e.sv = !tmo;
                if (srdy[d] || tmo) begin
                    fin = 1;
                    e.rdy[n] = 1'b1;
                    e.err[n] = tmo;
                    if (n == 0) e.rd0 = srd[d]; else e.rd1 = srd[d];
                end
            end
        end
    endtask

    task automatic model_step(input int d, input bit fin, input bit abort);
        if (owner[d] < 0) begin
            age[d] = 0;
            if (mv[d][0] && mv[d][1]) owner[d] = rrb[d] ? 1 - last[d] : 0;
            else if (mv[d][0])        owner[d] = 0;
            else if (mv[d][1])        owner[d] = 1;
        end else if (abort) begin
            owner[d] = -1;
        end else if (fin) begin
            last[d]  = owner[d];
            owner[d] = -1;
        end else begin
            age[d]++;
        end
    endtask

    initial begin
        outs_t Z;
        outs_t e;
        bit    fin, abort;
        bit    seen [2][2];
        Z = '0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            drive(d, 2'b11, 16'h0101, 16'h0202, 2'b11, 16'h3333, 1'b1, 16'h4444);
        end

        // Reset: outputs idle even with requests and s_ready present.
        #3;
        check(0, "reset_idle", Z);
        check(1, "reset_idle", Z);
        next_cycle();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        drive(1, 2'b00, '0, '0, '0, '0, 1'b0, '0);

        // Single core read
        row(2'b01, 16'h0100, 16'h0, 2'b00, 16'h0, 1'b0, 16'h0,    Z);
        row(2'b01, 16'h0100, 16'h0, 2'b00, 16'h0, 1'b0, 16'h0,    o(1'b1, 16'h0100, 2'b00, 16'h0, 2'b00, 2'b00, 16'h0));
        row(2'b01, 16'h0100, 16'h0, 2'b00, 16'h0, 1'b1, 16'hBEEF, o(1'b1, 16'h0100, 2'b00, 16'h0, 2'b01, 2'b00, 16'hBEEF));
        row(2'b00, 16'h0,    16'h0, 2'b00, 16'h0, 1'b0, 16'h0,    Z);
        // Write pass-through from master 1
        row(2'b10, 16'h0, 16'h2000, 2'b01, 16'h1234, 1'b0, 16'h0,    Z);
        row(2'b10, 16'h0, 16'h2000, 2'b01, 16'h1234, 1'b0, 16'h0,    o(1'b1, 16'h2000, 2'b01, 16'h1234, 2'b00, 2'b00, 16'h0));
        row(2'b10, 16'h0, 16'h2000, 2'b01, 16'h1234, 1'b1, 16'h5A5A, o(1'b1, 16'h2000, 2'b01, 16'h1234, 2'b10, 2'b00, 16'h5A5A));
        row(2'b00, 16'h0, 16'h0,    2'b00, 16'h0,    1'b0, 16'h0,    Z);
        // Round-robin tie, zero-wait memory; s_ready in IDLE is ignored
        row(2'b11, 16'h0300, 16'h0400, 2'b10, 16'h1111, 1'b0, 16'h0,    Z);
        row(2'b11, 16'h0300, 16'h0400, 2'b10, 16'h1111, 1'b1, 16'hAAAA, o(1'b1, 16'h0300, 2'b00, 16'h0, 2'b01, 2'b00, 16'hAAAA));
        row(2'b11, 16'h0300, 16'h0400, 2'b10, 16'h1111, 1'b1, 16'h0,    Z);
        row(2'b11, 16'h0300, 16'h0400, 2'b10, 16'h1111, 1'b1, 16'hBBBB, o(1'b1, 16'h0400, 2'b10, 16'h1111, 2'b10, 2'b00, 16'hBBBB));
        row(2'b11, 16'h0300, 16'h0400, 2'b10, 16'h1111, 1'b0, 16'h0,    Z);
        row(2'b11, 16'h0300, 16'h0400, 2'b10, 16'h1111, 1'b1, 16'hCCCC, o(1'b1, 16'h0300, 2'b00, 16'h0, 2'b01, 2'b00, 16'hCCCC));
        row(2'b11, 16'h0300, 16'h0400, 2'b10, 16'h1111, 1'b0, 16'h0,    Z);
        row(2'b11, 16'h0300, 16'h0400, 2'b10, 16'h1111, 1'b1, 16'hDDDD, o(1'b1, 16'h0400, 2'b10, 16'h1111, 2'b10, 2'b00, 16'hDDDD));
        row(2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 1'b0, 16'h0, Z);
        // Master 0 timeout in its 4th granted cycle
        row(2'b01, 16'h0500, 16'h0, 2'b00, 16'h0, 1'b0, 16'h0, Z);
        for (int i = 0; i < 3; i++)
            row(2'b01, 16'h0500, 16'h0, 2'b00, 16'h0, 1'b0, 16'h0, o(1'b1, 16'h0500, 2'b00, 16'h0, 2'b00, 2'b00, 16'h0));
        row(2'b01, 16'h0500, 16'h0, 2'b00, 16'h0, 1'b0, 16'h1357, o(1'b0, 16'h0500, 2'b00, 16'h0, 2'b01, 2'b01, 16'h1357));
        row(2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 1'b0, 16'h0, Z);
        // s_ready coinciding with expiry is a normal completion
        row(2'b01, 16'h0600, 16'h0, 2'b00, 16'h0, 1'b0, 16'h0, Z);
        for (int i = 0; i < 3; i++)
            row(2'b01, 16'h0600, 16'h0, 2'b00, 16'h0, 1'b0, 16'h0, o(1'b1, 16'h0600, 2'b00, 16'h0, 2'b00, 2'b00, 16'h0));
        row(2'b01, 16'h0600, 16'h0, 2'b00, 16'h0, 1'b1, 16'hCAFE, o(1'b1, 16'h0600, 2'b00, 16'h0, 2'b01, 2'b00, 16'hCAFE));
        row(2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 1'b0, 16'h0, Z);
        // Abort: owner drops valid, no ready pulse
        row(2'b10, 16'h0, 16'h0700, 2'b00, 16'h0, 1'b0, 16'h0, Z);
        row(2'b10, 16'h0, 16'h0700, 2'b00, 16'h0, 1'b0, 16'h0, o(1'b1, 16'h0700, 2'b00, 16'h0, 2'b00, 2'b00, 16'h0));
        row(2'b00, 16'h0, 16'h0700, 2'b00, 16'h0, 1'b0, 16'h0, o(1'b0, 16'h0700, 2'b00, 16'h0, 2'b00, 2'b00, 16'h0));
        row(2'b00, 16'h0, 16'h0,    2'b00, 16'h0, 1'b1, 16'h0, Z);
        // Master 1 timeout: err only to master 1
        row(2'b10, 16'h0, 16'h0800, 2'b11, 16'hFFFF, 1'b0, 16'h0, Z);
        for (int i = 0; i < 3; i++)
            row(2'b10, 16'h0, 16'h0800, 2'b11, 16'hFFFF, 1'b0, 16'h0, o(1'b1, 16'h0800, 2'b11, 16'hFFFF, 2'b00, 2'b00, 16'h0));
        row(2'b10, 16'h0, 16'h0800, 2'b11, 16'hFFFF, 1'b0, 16'h2468, o(1'b0, 16'h0800, 2'b11, 16'hFFFF, 2'b10, 2'b10, 16'h2468));
        row(2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 1'b0, 16'h0, Z);

        foreach (tbl[i]) begin
            drive(0, tbl[i].mv, tbl[i].a0, tbl[i].a1, tbl[i].ws1, tbl[i].wd1, tbl[i].srdy, tbl[i].rd);
            #2;
            check(0, $sformatf("table_row%0d", i), tbl[i].exp);
            next_cycle();
        end

        // Reset while master 1 is granted, then both request: master 0 wins first
        drive(0, 2'b10, 16'h0, 16'h0900, 2'b01, 16'h0909, 1'b0, 16'h0);
        next_cycle();
        #2;
        check(0, "pre_reset_grant1", o(1'b1, 16'h0900, 2'b01, 16'h0909, 2'b00, 2'b00, 16'h0));
        rst_n[0] = 1'b0;
        srdy[0]  = 1'b1;
        #1;
        check(0, "async_reset_outputs", Z);
        next_cycle();
        drive(0, 2'b11, 16'h0A00, 16'h0900, 2'b01, 16'h0909, 1'b0, 16'h0);
        #1;
        rst_n[0] = 1'b1;
        #1;
        check(0, "reset_release_idle", Z);
        next_cycle();
        #2;
        check(0, "post_reset_m0_first", o(1'b1, 16'h0A00, 2'b00, 16'h0, 2'b00, 2'b00, 16'h0));
        drive(0, 2'b11, 16'h0A00, 16'h0900, 2'b01, 16'h0909, 1'b1, 16'h7777);
        #1;
        check(0, "post_reset_m0_done", o(1'b1, 16'h0A00, 2'b00, 16'h0, 2'b01, 2'b00, 16'h7777));
        next_cycle();
        drive(0, 2'b00, '0, '0, '0, '0, 1'b0, '0);

        // Fixed priority: master 0 wins every tie
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'b11, 16'h1000 + 16'(k), 16'h2000, 2'b01, 16'h2222, 1'b0, 16'h0);
            #2;
            check(1, "fp_idle", Z);
            next_cycle();
            drive(1, 2'b11, 16'h1000 + 16'(k), 16'h2000, 2'b01, 16'h2222, 1'b1, 16'h0F00 + 16'(k));
            #2;
            check(1, "fp_m0_wins", o(1'b1, 16'h1000 + 16'(k), 2'b00, 16'h0, 2'b01, 2'b00, 16'h0F00 + 16'(k)));
            next_cycle();
        end
        drive(1, 2'b10, 16'h0, 16'h2000, 2'b01, 16'h2222, 1'b0, 16'h0);
        #2;
        check(1, "fp_idle_m1", Z);
        next_cycle();
        drive(1, 2'b10, 16'h0, 16'h2000, 2'b01, 16'h2222, 1'b1, 16'h3C3C);
        #2;
        check(1, "fp_m1_granted", o(1'b1, 16'h2000, 2'b01, 16'h2222, 2'b10, 2'b00, 16'h3C3C));
        next_cycle();
        // Watchdog disabled: a long stall never errors
        drive(1, 2'b01, 16'h3000, 16'h0, 2'b00, 16'h0, 1'b0, 16'h0);
        next_cycle();
        for (int k = 0; k < 300; k++) begin
            #2;
            check(1, "no_watchdog_stall", o(1'b1, 16'h3000, 2'b00, 16'h0, 2'b00, 2'b00, 16'h0));
            next_cycle();
        end
        srdy[1] = 1'b1; srd[1] = 16'h9999;
        #2;
        check(1, "no_watchdog_done", o(1'b1, 16'h3000, 2'b00, 16'h0, 2'b01, 2'b00, 16'h9999));
        next_cycle();

        // Randomized traffic against the reference model, both configurations
        for (int d = 0; d < 2; d++) begin
            drive(d, 2'b00, '0, '0, '0, '0, 1'b0, '0);
            rst_n[d] = 1'b0;
            owner[d] = -1; last[d] = 1; age[d] = 0;
            seen[d][0] = 0; seen[d][1] = 0;
        end
        lim[0] = 4; lim[1] = 0;
        rrb[0] = 1; rrb[1] = 0;
        next_cycle();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int m = 0; m < 2; m++) begin
                    if (mv[d][m] && seen[d][m]) begin
                        mv[d][m] = 1'b0;
                    end else if (!mv[d][m] && ($urandom_range(1, 0) == 1)) begin
                        mv[d][m]  = 1'b1;
                        ma[d][m]  = 16'($urandom);
                        mws[d][m] = 2'($urandom);
                        mwd[d][m] = 16'($urandom);
                    end
                end
                srdy[d] = ($urandom_range(3, 0) == 0);
                srd[d]  = 16'($urandom);
            end
            #2;
            for (int d = 0; d < 2; d++) begin
                model_out(d, e, fin, abort);
                check(d, "random", e);
                seen[d][0] = e.rdy[0];
                seen[d][1] = e.rdy[1];
                model_step(d, fin, abort);
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-master, one-slave arbiter for the 16-bit memory port.
- Shares the single memory between the CPU core (master 0) and a loader/DMA engine (master 1).
- Uses the core's valid/ready protocol on every port: a master holds valid until it sees a one-cycle ready pulse, then drops valid.
- Adds round-robin or fixed-priority arbitration, a bus lock per transaction, and a watchdog that ends hung transactions with an error.

## Interface

Parameters:

- ADDR_W, 16, address width
- DATA_W, 16, data width; strobe width is DATA_W/8
- ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority with master 0 highest
- TIMEOUT, 255, watchdog limit in granted cycles; 0 disables the watchdog

Ports (one clock; reset is asynchronous and active-low):

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_valid / m1_valid  in  1  master request, held until that master's ready
- m0_addr / m1_addr  in  ADDR_W  request address
- m0_wstrb / m1_wstrb  in  DATA_W/8  byte write strobes; 0 = read
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_ready / m1_ready  out  1  completion pulse to that master
- m0_err / m1_err  out  1  high together with ready when the watchdog expired
- m_rdata  out  DATA_W  s_rdata broadcast to both masters
- s_valid  out  1  request to memory
- s_addr  out  ADDR_W  address to memory
- s_wstrb  out  DATA_W/8  strobes to memory
- s_wdata  out  DATA_W  write data to memory
- s_ready  in  1  memory completion pulse
- s_rdata  in  DATA_W  memory read data

## Operation

- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - Only m0_valid high: go to GRANT0.
  - Only m1_valid high: go to GRANT1.
  - Both high, ROUND_ROBIN=1: grant the master that was not granted last.
  - Both high, ROUND_ROBIN=0: grant master 0.
- GRANTn, slave side:
  - s_valid = mn_valid.
  - s_addr, s_wstrb and s_wdata mux from master n.
  - The other master's valid is ignored; it waits.
- GRANTn, completion:
  - s_ready high makes mn_ready = 1 in that same cycle (combinational).
  - Next state is IDLE; last_grant is set to n.
  - s_ready is ignored in IDLE.
- Watchdog:
  - A counter clears on entry to GRANTn and increments each cycle in GRANTn.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with no s_ready: mn_ready=1, mn_err=1, s_valid forced to 0 in that cycle, next state IDLE.
  - The counter is sized for TIMEOUT and saturates.
- Abort: mn_valid low while in GRANTn is a protocol violation. Return to IDLE with no ready pulse.
- Simultaneous events: s_ready and watchdog expiry in the same cycle is a normal completion; err stays 0.
- Ready and err never go to a non-granted master.

## Timing

- Reset (async assert, release synchronous to clk):
  - State IDLE; last_grant = 1, so master 0 wins the first tie.
  - Counter 0.
  - All s_* outputs 0; m*_ready and m*_err 0.
- In IDLE, s_valid=0 and s_addr/s_wstrb/s_wdata=0.
- Arbitration latency is 1 cycle: mn_valid sampled high in IDLE at edge t gives s_valid=1 from cycle t+1.
- Completion: a ready pulse in cycle c returns the arbiter to IDLE at edge c+1, the same edge at which the master drops valid. Back-to-back use therefore costs one IDLE cycle per transaction.
- Zero-wait memory (s_ready in the first granted cycle): 2 cycles per transaction.
- m_rdata is combinational from s_rdata and is valid only in the ready cycle.
- Reset mid-transaction: s_valid drops immediately (async); no ready is issued.

## Structure

- The shared def package holds:
  - arb_state_t {IDLE, GRANT0, GRANT1}
  - ARB_M_CORE=0 and ARB_M_DMA=1 constants
- The watchdog counter is the only natural sub-module: bus_watchdog (clear, enable, limit, expired).
- Muxes and the FSM stay in mem_arbiter.

## Test plan

- **Single core read:** m0_valid, addr 0x0100, wstrb 0; memory ready after 2 cycles with rdata 0xBEEF. Expect s_valid from cycle 1, m0_ready pulse with m_rdata 0xBEEF, m1_ready=0.
- **Round-robin tie:** both valid continuously, ROUND_ROBIN=1, zero-wait memory. Expect grants 0,1,0,1 with one IDLE cycle between them.
- **Fixed priority:** the same tie with ROUND_ROBIN=0. Expect master 0 to win every arbitration while it requests; master 1 is granted only when m0_valid is low in IDLE.
- **Write pass-through:** m1 writes 0x1234 with wstrb 2'b01 to 0x2000. Expect s_addr 0x2000, s_wstrb 01, s_wdata 0x1234 while granted, then an m1_ready pulse.
- **Timeout:** TIMEOUT=4, memory never ready. Expect m0_ready=1 and m0_err=1 in the 4th granted cycle, s_valid=0 in that cycle, then IDLE. With s_ready in the same cycle instead, expect err=0.
- **Reset mid-operation:** rst_n low while in GRANT1. Expect all outputs 0 immediately. After release with both masters valid, expect master 0 granted first.
